// File: rtl/lsu_mem_port.sv
// Load/store unit: steers CPU loads/stores onto a handshaked word-wide data memory,
// with alignment checking, sign/zero load extension and a bus timeout.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic [1:0]  loadStoreWidth,
  input  logic        loadSign,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic        done,
  output logic [31:0] loadData,
  output logic        fault_align,
  output logic        fault_bus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic        TmoEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [15:0] tmo_cnt_q;
  logic        store_q;
  logic [1:0]  width_q;
  logic        sign_q;
  logic [1:0]  lo_q;

  logic        op;
  logic        misaligned;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  assign op    = req_valid & (MemWrite | MemtoReg);
  assign stall = ((state_q == StIdle) & op) | (state_q == StReq);

  always_comb begin
    misaligned = 1'b0;
    wstrb_n    = 4'b0000;
    wdata_n    = 32'h0;
    unique case (loadStoreWidth)
      2'b00: begin
        wdata_n = {4{storeData[7:0]}};
        wstrb_n = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        misaligned = addr[0];
        wdata_n    = {2{storeData[15:0]}};
        wstrb_n    = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b11: begin
        misaligned = (addr[1:0] != 2'b00);
        wdata_n    = storeData;
        wstrb_n    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Extraction uses the offset/width latched at acceptance, not the live inputs.
  always_comb begin
    rd_byte = 8'h0;
    unique case (lo_q)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half  = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    if (width_q == 2'b00) begin
      load_ext = sign_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
    end else if (width_q == 2'b01) begin
      load_ext = sign_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= 16'h0;
      store_q     <= 1'b0;
      width_q     <= 2'b00;
      sign_q      <= 1'b0;
      lo_q        <= 2'b00;
      done        <= 1'b0;
      loadData    <= 32'h0;
      fault_align <= 1'b0;
      fault_bus   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wstrb   <= 4'b0000;
      mem_wdata   <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op) begin
            store_q <= MemWrite;
            width_q <= loadStoreWidth;
            sign_q  <= loadSign;
            lo_q    <= addr[1:0];
            if (!misaligned) begin
              state_q   <= StReq;
              tmo_cnt_q <= 16'h0;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= MemWrite ? wstrb_n : 4'b0000;
              mem_wdata <= MemWrite ? wdata_n : 32'h0;
            end else begin
              state_q     <= StDone;
              done        <= 1'b1;
              fault_align <= 1'b1;
              loadData    <= 32'h0;
            end
          end
        end
        StReq: begin
          if (mem_ack || (TmoEn && tmo_cnt_q == TmoLast)) begin
            state_q   <= StDone;
            done      <= 1'b1;
            fault_bus <= ~mem_ack;
            loadData  <= (mem_ack && !store_q) ? load_ext : 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'h1;
          end
        end
        StDone: begin
          state_q     <= StIdle;
          done        <= 1'b0;
          fault_align <= 1'b0;
          fault_bus   <= 1'b0;
          loadData    <= 32'h0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
